eth_rx_word_packer: RTL



---
 rtl/eth_rx_word_packer.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/eth_rx_word_packer.sv
// eth_rx_word_packer: packs the MAC RX byte stream into 32-bit AXI-Stream words.
// Frames are truncated to MAX_BYTES; a byte-length strobe is emitted per frame.
// Optional feature macro: ETH_RX_PACKER_ERR_EN (adds m_axis_tuser on the tlast word).
module eth_rx_word_packer #(
  parameter int unsigned MAX_BYTES = 2048,
  parameter int unsigned LEN_W     = 16
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic [7:0]       s_axis_tdata,
  input  logic             s_axis_tvalid,
  input  logic             s_axis_tlast,
  input  logic             s_axis_tuser,
  output logic             s_axis_tready,
  output logic [31:0]      m_axis_tdata,
  output logic [3:0]       m_axis_tkeep,
  output logic             m_axis_tvalid,
  output logic             m_axis_tlast,
`ifdef ETH_RX_PACKER_ERR_EN
  output logic             m_axis_tuser,
`endif
  input  logic             m_axis_tready,
  output logic [LEN_W-1:0] frame_len,
  output logic             frame_len_vld
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned ACC_W  = 3 * BYTE_W;
  localparam int unsigned DATA_W = 4 * BYTE_W;
  localparam int unsigned KEEP_W = 4;
  localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_BYTES);

  typedef enum logic [0:0] {
    ST_PACK    = 1'b0,
    ST_DISCARD = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          lane_q, lane_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [LEN_W-1:0]    byte_cnt_q, byte_cnt_d;
  logic [DATA_W-1:0]   tdata_q, tdata_d;
  logic [KEEP_W-1:0]   tkeep_q, tkeep_d;
  logic                tvalid_q, tvalid_d;
  logic                tlast_q, tlast_d;
  logic                tuser_q, tuser_d;
  logic [LEN_W-1:0]    frame_len_q, frame_len_d;
  logic                frame_len_vld_q, frame_len_vld_d;

  logic                s_ready_c;
  logic                byte_acc_c;
  logic [LEN_W-1:0]    cnt_inc_c;
  logic                hit_max_c;

  // Merge the held bytes with the completing byte; lanes above it stay zero.
  function automatic logic [DATA_W-1:0] pack_word(input logic [ACC_W-1:0] acc,
                                                  input logic [1:0] lane,
                                                  input logic [BYTE_W-1:0] b);
    logic [DATA_W-1:0] w;
    w = '0;
    case (lane)
      2'd0:    w = {24'h0, b};
      2'd1:    w = {16'h0, b, acc[7:0]};
      2'd2:    w = {8'h0, b, acc[15:0]};
      default: w = {b, acc};
    endcase
    return w;
  endfunction

  // Contiguous lane mask for a word completed at the given lane.
  function automatic logic [KEEP_W-1:0] keep_mask(input logic [1:0] lane);
    logic [KEEP_W-1:0] k;
    case (lane)
      2'd0:    k = 4'b0001;
      2'd1:    k = 4'b0011;
      2'd2:    k = 4'b0111;
      default: k = 4'b1111;
    endcase
    return k;
  endfunction

  // Upstream backpressure: only a stalled pending word blocks packing.
  assign s_ready_c  = (state_q == ST_DISCARD) ? 1'b1 : !(tvalid_q && !m_axis_tready);
  assign byte_acc_c = s_axis_tvalid && s_ready_c;
  assign cnt_inc_c  = (byte_cnt_q >= MAX_CNT) ? MAX_CNT : byte_cnt_q + LEN_W'(1);

  // Next-state, accumulator, output-register and length-strobe logic.
  always_comb begin
    state_d         = state_q;
    lane_d          = lane_q;
    acc_d           = acc_q;
    byte_cnt_d      = byte_cnt_q;
    tdata_d         = tdata_q;
    tkeep_d         = tkeep_q;
    tvalid_d        = tvalid_q;
    tlast_d         = tlast_q;
    tuser_d         = tuser_q;
    frame_len_d     = frame_len_q;
    frame_len_vld_d = 1'b0;
    hit_max_c       = 1'b0;

    // Accepted word with nothing new behind it: clear the output register.
    if (tvalid_q && m_axis_tready) begin
      tdata_d  = '0;
      tkeep_d  = '0;
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
      tuser_d  = 1'b0;
    end

    case (state_q)
      ST_PACK: begin
        if (byte_acc_c) begin
          byte_cnt_d = cnt_inc_c;
          hit_max_c  = (cnt_inc_c == MAX_CNT);
          if ((lane_q == 2'd3) || s_axis_tlast || hit_max_c) begin
            tdata_d  = pack_word(acc_q, lane_q, s_axis_tdata);
            tkeep_d  = keep_mask(lane_q);
            tvalid_d = 1'b1;
            tlast_d  = s_axis_tlast || hit_max_c;
            tuser_d  = s_axis_tlast ? s_axis_tuser : hit_max_c;
            lane_d   = 2'd0;
            acc_d    = '0;
          end else begin
            case (lane_q)
              2'd0:    acc_d[7:0]   = s_axis_tdata;
              2'd1:    acc_d[15:8]  = s_axis_tdata;
              default: acc_d[23:16] = s_axis_tdata;
            endcase
            lane_d = lane_q + 2'd1;
          end
          if (s_axis_tlast) begin
            frame_len_d     = cnt_inc_c;
            frame_len_vld_d = 1'b1;
            byte_cnt_d      = '0;
          end else if (hit_max_c) begin
            state_d = ST_DISCARD;
          end
        end
      end
      ST_DISCARD: begin
        if (byte_acc_c && s_axis_tlast) begin
          frame_len_d     = byte_cnt_q;
          frame_len_vld_d = 1'b1;
          byte_cnt_d      = '0;
          lane_d          = 2'd0;
          acc_d           = '0;
          state_d         = ST_PACK;
        end
      end
      default: state_d = ST_PACK;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q         <= ST_PACK;
      lane_q          <= '0;
      acc_q           <= '0;
      byte_cnt_q      <= '0;
      tdata_q         <= '0;
      tkeep_q         <= '0;
      tvalid_q        <= 1'b0;
      tlast_q         <= 1'b0;
      tuser_q         <= 1'b0;
      frame_len_q     <= '0;
      frame_len_vld_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      lane_q          <= lane_d;
      acc_q           <= acc_d;
      byte_cnt_q      <= byte_cnt_d;
      tdata_q         <= tdata_d;
      tkeep_q         <= tkeep_d;
      tvalid_q        <= tvalid_d;
      tlast_q         <= tlast_d;
      tuser_q         <= tuser_d;
      frame_len_q     <= frame_len_d;
      frame_len_vld_q <= frame_len_vld_d;
    end
  end

  assign s_axis_tready = s_ready_c;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign frame_len     = frame_len_q;
  assign frame_len_vld = frame_len_vld_q;

`ifdef ETH_RX_PACKER_ERR_EN
  assign m_axis_tuser = tuser_q;
`else
  // Error flag has no destination without the tuser output.
  logic unused_tuser;
  assign unused_tuser = tuser_q ^ s_axis_tuser;
`endif

endmodule
